// File: rtl/channel_deserializer.sv
// RX-side channel deserializer: reads framed 64-bit words from the RX FIFO, parses
// header / payload / footer framing and routes each payload to one of 8 AXIS-style
// channel outputs (no TREADY). Keeps frame, header-error and drop counters.
// Word layout assumes a 64-bit serialized word (header id in [63:56]).
module channel_deserializer #(
    parameter int unsigned M_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned TX_RX_S_AXIS_WIDTH = 64,
    parameter logic [7:0]  HEADER_ID          = 8'hAA,
    parameter logic [7:0]  FOOTER_ID          = 8'h55,
    parameter int unsigned MAX_FRAME_WORDS    = 1600
) (
    input  logic                          RX_ACLK,
    input  logic                          RX_ARESETN,
    input  logic [TX_RX_S_AXIS_WIDTH-1:0] SERIALIZED_DATA,
    input  logic                          DATA_EMPTY,
    input  logic                          PLS_WAIT,
    output logic                          RE_EN,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M0_AXIS_TDATA,
    output logic                          M0_AXIS_TVALID,
    output logic                          M0_AXIS_TUSER,
    output logic                          M0_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M1_AXIS_TDATA,
    output logic                          M1_AXIS_TVALID,
    output logic                          M1_AXIS_TUSER,
    output logic                          M1_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M2_AXIS_TDATA,
    output logic                          M2_AXIS_TVALID,
    output logic                          M2_AXIS_TUSER,
    output logic                          M2_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M3_AXIS_TDATA,
    output logic                          M3_AXIS_TVALID,
    output logic                          M3_AXIS_TUSER,
    output logic                          M3_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M4_AXIS_TDATA,
    output logic                          M4_AXIS_TVALID,
    output logic                          M4_AXIS_TUSER,
    output logic                          M4_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M5_AXIS_TDATA,
    output logic                          M5_AXIS_TVALID,
    output logic                          M5_AXIS_TUSER,
    output logic                          M5_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M6_AXIS_TDATA,
    output logic                          M6_AXIS_TVALID,
    output logic                          M6_AXIS_TUSER,
    output logic                          M6_AXIS_TLAST,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M7_AXIS_TDATA,
    output logic                          M7_AXIS_TVALID,
    output logic                          M7_AXIS_TUSER,
    output logic                          M7_AXIS_TLAST,
    output logic [15:0]                   FRAME_CNT,
    output logic [15:0]                   HEADER_ERR_CNT,
    output logic [15:0]                   DROP_CNT,
    output logic                          FOOTER_ERR
);

    localparam int unsigned NumCh = 8;

    typedef enum logic [1:0] {StIdle, StPayload, StDrop, StFooter} state_e;

    state_e state_q, state_d;
    logic        word_valid_q;
    logic [2:0]  ch_q, ch_d;
    logic [15:0] remain_q, remain_d;
    logic        first_q, first_d;
    logic        dropped_q, dropped_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] hdr_err_cnt_q, hdr_err_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        footer_err_q, footer_err_d;

    logic [M_AXIS_TDATA_WIDTH-1:0] tdata_q [NumCh];
    logic [M_AXIS_TDATA_WIDTH-1:0] tdata_d [NumCh];
    logic [NumCh-1:0] tvalid_q, tvalid_d;
    logic [NumCh-1:0] tuser_q, tuser_d;
    logic [NumCh-1:0] tlast_q, tlast_d;

    // Header field decode
    logic [7:0]  word_id;
    logic [3:0]  hdr_ch;
    logic [15:0] hdr_len;
    logic        hdr_ok;

    assign word_id = SERIALIZED_DATA[63:56];
    assign hdr_ch  = SERIALIZED_DATA[51:48];
    assign hdr_len = SERIALIZED_DATA[47:32];
    assign hdr_ok  = (word_id == HEADER_ID) && (hdr_len != 16'd0) &&
                     (hdr_len <= 16'(MAX_FRAME_WORDS));

    // Reads are gated by reset so a read can never be issued while held in reset
    assign RE_EN = !DATA_EMPTY && !PLS_WAIT && RX_ARESETN;

    // Read data is valid exactly one cycle after an accepted read
    always_ff @(posedge RX_ACLK) begin
        if (!RX_ARESETN) begin
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= RE_EN;
        end
    end

    // Framing FSM, counters and registered channel outputs
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        remain_d      = remain_q;
        first_d       = first_q;
        dropped_d     = dropped_q;
        frame_cnt_d   = frame_cnt_q;
        hdr_err_cnt_d = hdr_err_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        footer_err_d  = 1'b0;
        tvalid_d      = '0;
        tuser_d       = '0;
        tlast_d       = '0;
        for (int k = 0; k < NumCh; k++) begin
            tdata_d[k] = tdata_q[k];
        end

        if (word_valid_q) begin
            unique case (state_q)
                StIdle: begin
                    if (hdr_ok) begin
                        ch_d      = hdr_ch[2:0];
                        remain_d  = hdr_len;
                        first_d   = 1'b1;
                        dropped_d = hdr_ch[3];
                        if (hdr_ch[3]) begin
                            state_d = StDrop;
                            if (drop_cnt_q != 16'hFFFF) begin
                                drop_cnt_d = drop_cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = StPayload;
                        end
                    end else if (hdr_err_cnt_q != 16'hFFFF) begin
                        // Stay in idle and hunt for the next header
                        hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
                    end
                end
                StPayload: begin
                    tdata_d[ch_q]  = SERIALIZED_DATA;
                    tvalid_d[ch_q] = 1'b1;
                    tuser_d[ch_q]  = first_q;
                    tlast_d[ch_q]  = (remain_q == 16'd1);
                    first_d        = 1'b0;
                    remain_d       = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = StFooter;
                    end
                end
                StDrop: begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = StFooter;
                    end
                end
                StFooter: begin
                    // A bad footer is consumed here, never re-parsed as a header
                    if (word_id == FOOTER_ID) begin
                        if (!dropped_q) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end else begin
                        footer_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge RX_ACLK) begin
        if (!RX_ARESETN) begin
            state_q       <= StIdle;
            ch_q          <= '0;
            remain_q      <= '0;
            first_q       <= 1'b0;
            dropped_q     <= 1'b0;
            frame_cnt_q   <= '0;
            hdr_err_cnt_q <= '0;
            drop_cnt_q    <= '0;
            footer_err_q  <= 1'b0;
            tvalid_q      <= '0;
            tuser_q       <= '0;
            tlast_q       <= '0;
            for (int k = 0; k < NumCh; k++) begin
                tdata_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            remain_q      <= remain_d;
            first_q       <= first_d;
            dropped_q     <= dropped_d;
            frame_cnt_q   <= frame_cnt_d;
            hdr_err_cnt_q <= hdr_err_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            footer_err_q  <= footer_err_d;
            tvalid_q      <= tvalid_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            for (int k = 0; k < NumCh; k++) begin
                tdata_q[k] <= tdata_d[k];
            end
        end
    end

    assign FRAME_CNT      = frame_cnt_q;
    assign HEADER_ERR_CNT = hdr_err_cnt_q;
    assign DROP_CNT       = drop_cnt_q;
    assign FOOTER_ERR     = footer_err_q;

    assign M0_AXIS_TDATA  = tdata_q[0];
    assign M0_AXIS_TVALID = tvalid_q[0];
    assign M0_AXIS_TUSER  = tuser_q[0];
    assign M0_AXIS_TLAST  = tlast_q[0];
    assign M1_AXIS_TDATA  = tdata_q[1];
    assign M1_AXIS_TVALID = tvalid_q[1];
    assign M1_AXIS_TUSER  = tuser_q[1];
    assign M1_AXIS_TLAST  = tlast_q[1];
    assign M2_AXIS_TDATA  = tdata_q[2];
    assign M2_AXIS_TVALID = tvalid_q[2];
    assign M2_AXIS_TUSER  = tuser_q[2];
    assign M2_AXIS_TLAST  = tlast_q[2];
    assign M3_AXIS_TDATA  = tdata_q[3];
    assign M3_AXIS_TVALID = tvalid_q[3];
    assign M3_AXIS_TUSER  = tuser_q[3];
    assign M3_AXIS_TLAST  = tlast_q[3];
    assign M4_AXIS_TDATA  = tdata_q[4];
    assign M4_AXIS_TVALID = tvalid_q[4];
    assign M4_AXIS_TUSER  = tuser_q[4];
    assign M4_AXIS_TLAST  = tlast_q[4];
    assign M5_AXIS_TDATA  = tdata_q[5];
    assign M5_AXIS_TVALID = tvalid_q[5];
    assign M5_AXIS_TUSER  = tuser_q[5];
    assign M5_AXIS_TLAST  = tlast_q[5];
    assign M6_AXIS_TDATA  = tdata_q[6];
    assign M6_AXIS_TVALID = tvalid_q[6];
    assign M6_AXIS_TUSER  = tuser_q[6];
    assign M6_AXIS_TLAST  = tlast_q[6];
    assign M7_AXIS_TDATA  = tdata_q[7];
    assign M7_AXIS_TVALID = tvalid_q[7];
    assign M7_AXIS_TUSER  = tuser_q[7];
    assign M7_AXIS_TLAST  = tlast_q[7];

endmodule

// File: tb/tb_channel_deserializer.sv
// Bench for channel_deserializer: frame-level stimulus feeds a FIFO model; expected beats
// and counter values are derived per frame and checked by a decoupled output monitor.
module tb_channel_deserializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] ser_data;
    logic        data_empty;
    logic        pls_wait;
    logic        re_en;
    logic [63:0] tdata [8];
    logic [7:0]  tvalid;
    logic [7:0]  tuser;
    logic [7:0]  tlast;
    logic [15:0] frame_cnt;
    logic [15:0] hdr_err_cnt;
    logic [15:0] drop_cnt;
    logic        footer_err;

    channel_deserializer dut (
        .RX_ACLK(clk), .RX_ARESETN(rst_n), .SERIALIZED_DATA(ser_data),
        .DATA_EMPTY(data_empty), .PLS_WAIT(pls_wait), .RE_EN(re_en),
        .M0_AXIS_TDATA(tdata[0]), .M0_AXIS_TVALID(tvalid[0]),
        .M0_AXIS_TUSER(tuser[0]), .M0_AXIS_TLAST(tlast[0]),
        .M1_AXIS_TDATA(tdata[1]), .M1_AXIS_TVALID(tvalid[1]),
        .M1_AXIS_TUSER(tuser[1]), .M1_AXIS_TLAST(tlast[1]),
        .M2_AXIS_TDATA(tdata[2]), .M2_AXIS_TVALID(tvalid[2]),
        .M2_AXIS_TUSER(tuser[2]), .M2_AXIS_TLAST(tlast[2]),
        .M3_AXIS_TDATA(tdata[3]), .M3_AXIS_TVALID(tvalid[3]),
        .M3_AXIS_TUSER(tuser[3]), .M3_AXIS_TLAST(tlast[3]),
        .M4_AXIS_TDATA(tdata[4]), .M4_AXIS_TVALID(tvalid[4]),
        .M4_AXIS_TUSER(tuser[4]), .M4_AXIS_TLAST(tlast[4]),
        .M5_AXIS_TDATA(tdata[5]), .M5_AXIS_TVALID(tvalid[5]),
        .M5_AXIS_TUSER(tuser[5]), .M5_AXIS_TLAST(tlast[5]),
        .M6_AXIS_TDATA(tdata[6]), .M6_AXIS_TVALID(tvalid[6]),
        .M6_AXIS_TUSER(tuser[6]), .M6_AXIS_TLAST(tlast[6]),
        .M7_AXIS_TDATA(tdata[7]), .M7_AXIS_TVALID(tvalid[7]),
        .M7_AXIS_TUSER(tuser[7]), .M7_AXIS_TLAST(tlast[7]),
        .FRAME_CNT(frame_cnt), .HEADER_ERR_CNT(hdr_err_cnt),
        .DROP_CNT(drop_cnt), .FOOTER_ERR(footer_err)
    );

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        user;
        logic        last;
    } beat_t;

    logic [63:0] fifo [$];
    beat_t       exp_q [$];
    int checks = 0;
    int failures = 0;
    int exp_frame = 0;
    int exp_hdr_err = 0;
    int exp_drop = 0;
    int exp_ferr = 0;
    int ferr_seen = 0;
    int gap_pct = 0;
    int wait_pct = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // FIFO model: first-word latency 1, random empty/stall gaps, junk on idle cycles
    initial begin
        logic took;
        ser_data   = '0;
        data_empty = 1'b1;
        pls_wait   = 1'b0;
        forever begin
            @(posedge clk);
            checks++;
            if (re_en !== (!data_empty && !pls_wait && rst_n)) begin
                failures++;
                $display("FAIL re_en: got %b required %b (empty=%b wait=%b rst_n=%b)",
                         re_en, (!data_empty && !pls_wait && rst_n), data_empty, pls_wait,
                         rst_n);
            end
            took = re_en;
            #1;
            if (took) begin
                checks++;
                if (fifo.size() == 0) begin
                    failures++;
                    $display("FAIL fifo_underflow: got read on empty FIFO, required none");
                end else begin
                    ser_data = fifo.pop_front();
                end
            end else begin
                ser_data = {$urandom, $urandom};
            end
            @(negedge clk);
            data_empty = (fifo.size() == 0) || ($urandom_range(99) < gap_pct);
            pls_wait   = ($urandom_range(99) < wait_pct);
        end
    end

    // Output monitor: pops the scoreboard whenever a beat appears
    initial begin
        beat_t e;
        int    nv;
        int    idx;
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                if (footer_err === 1'b1) ferr_seen++;
                nv  = $countones(tvalid);
                idx = 0;
                for (int k = 0; k < 8; k++) if (tvalid[k]) idx = k;
                checks++;
                if (((tuser | tlast) & ~tvalid) != 8'h00 || nv > 1) begin
                    failures++;
                    $display("FAIL strobes: got tvalid=%b tuser=%b tlast=%b, required one-hot",
                             tvalid, tuser, tlast);
                end else if (nv == 1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL beat: got unexpected beat on ch=%0d, required none", idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (idx != e.ch || tdata[idx] !== e.data || tuser[idx] !== e.user ||
                            tlast[idx] !== e.last) begin
                            failures++;
                            $display("FAIL beat: got ch=%0d data=%h user=%b last=%b required ch=%0d data=%h user=%b last=%b",
                                     idx, tdata[idx], tuser[idx], tlast[idx], e.ch, e.data,
                                     e.user, e.last);
                        end
                    end
                end
            end
        end
    end

    task automatic sat_inc(inout int v);
        if (v < 65535) v++;
    endtask

    // One complete frame; channels 8..15 are dropped
    task automatic send_frame(input int ch, input int len, input logic [7:0] footer_id);
        logic [63:0] w;
        logic [3:0]  c;
        logic [15:0] l;
        beat_t       b;
        c = ch[3:0];
        l = len[15:0];
        w = {$urandom, $urandom};
        w[63:56] = 8'hAA;
        w[51:48] = c;
        w[47:32] = l;
        fifo.push_back(w);
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            fifo.push_back(w);
            if (ch < 8) begin
                b.ch = ch; b.data = w; b.user = (i == 0); b.last = (i == len - 1);
                exp_q.push_back(b);
            end
        end
        if (ch >= 8) sat_inc(exp_drop);
        w = {$urandom, $urandom};
        w[63:56] = footer_id;
        fifo.push_back(w);
        if (footer_id == 8'h55) begin
            if (ch < 8) exp_frame = (exp_frame + 1) % 65536;
        end else begin
            exp_ferr++;
        end
    endtask

    // A word that must be rejected as a header
    task automatic send_garbage(input int kind);
        logic [63:0] w;
        w = {$urandom, $urandom};
        case (kind)
            0: if (w[63:56] == 8'hAA) w[63:56] = 8'h12;
            1: begin w[63:56] = 8'hAA; w[47:32] = 16'd0; end
            default: begin
                w[63:56] = 8'hAA;
                w[47:32] = 16'(1601 + $urandom_range(60000));
            end
        endcase
        fifo.push_back(w);
        sat_inc(exp_hdr_err);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        checks++;
        if (fifo.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got fifo=%0d pending_beats=%0d, required 0 and 0",
                     fifo.size(), exp_q.size());
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        checks++;
        if (frame_cnt != 16'(exp_frame) || hdr_err_cnt != 16'(exp_hdr_err) ||
            drop_cnt != 16'(exp_drop) || ferr_seen != exp_ferr) begin
            failures++;
            $display("FAIL counters_%s: got frame=%0d hdr=%0d drop=%0d ferr=%0d required %0d %0d %0d %0d",
                     tag, frame_cnt, hdr_err_cnt, drop_cnt, ferr_seen, exp_frame,
                     exp_hdr_err, exp_drop, exp_ferr);
        end
    endtask

    task automatic check_reset_outputs();
        logic any_data;
        any_data = 1'b0;
        for (int k = 0; k < 8; k++) if (tdata[k] !== 64'd0) any_data = 1'b1;
        checks++;
        if (tvalid !== 8'h00 || tuser !== 8'h00 || tlast !== 8'h00 || any_data ||
            frame_cnt !== 16'd0 || hdr_err_cnt !== 16'd0 || drop_cnt !== 16'd0 ||
            footer_err !== 1'b0 || re_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got tvalid=%b tuser=%b tlast=%b data_nz=%b cnt=%0d/%0d/%0d ferr=%b re_en=%b, required all 0",
                     tvalid, tuser, tlast, any_data, frame_cnt, hdr_err_cnt, drop_cnt,
                     footer_err, re_en);
        end
    endtask

    initial begin
        beat_t b;
        int    ch;
        int    len;
        logic [7:0] fid;
        rst_n = 1'b0;
        // Frame queued during reset: RE_EN must stay low until release
        send_frame(3, 4, 8'h55);
        repeat (3) begin
            @(posedge clk);
            #3;
            check_reset_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        check_counters("ch3_len4");

        send_frame(5, 1, 8'h55);
        drain();
        check_counters("ch5_len1");

        gap_pct = 40; wait_pct = 30;
        send_frame(0, 3, 8'h55);
        drain();
        check_counters("ch0_gaps");
        gap_pct = 0; wait_pct = 0;

        fifo.push_back(64'h1234_5678_9abc_def0);
        sat_inc(exp_hdr_err);
        send_frame(9, 2, 8'h55);
        drain();
        check_counters("garbage_drop");

        send_frame(2, 2, 8'h00);
        send_frame(2, 1, 8'h55);
        drain();
        check_counters("bad_footer");

        // Abandon an L=5 frame after two beats
        send_frame(4, 5, 8'h55);
        void'(fifo.pop_back());
        repeat (3) void'(fifo.pop_back());
        exp_frame--;
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        exp_frame = 0; exp_hdr_err = 0; exp_drop = 0;
        repeat (3) begin
            @(posedge clk);
            #3;
            check_reset_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(1, 2, 8'h55);
        drain();
        check_counters("after_reset");

        // Randomized traffic
        gap_pct = 20; wait_pct = 10;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(4) == 0) send_garbage(int'($urandom_range(2)));
            ch  = ($urandom_range(5) == 0) ? int'($urandom_range(15, 8)) :
                                             int'($urandom_range(7));
            len = int'($urandom_range(8, 1));
            fid = 8'h55;
            if ($urandom_range(9) == 0) begin
                fid = 8'($urandom);
                if (fid == 8'h55) fid = 8'h00;
            end
            send_frame(ch, len, fid);
        end
        drain();
        check_counters("random");

        // Length boundaries
        send_garbage(1);
        fifo.push_back({8'hAA, 4'h0, 4'h6, 16'd1601, 32'h0});
        sat_inc(exp_hdr_err);
        send_frame(6, 1600, 8'h55);
        drain();
        check_counters("len_bounds");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_deserializer.md
Name: channel_deserializer

Overview:
- RX-side counterpart of the 8-channel TX serializer on the SFP link.
- Reads framed 64-bit words from the RX data FIFO through a first-word-latency-1 read interface.
- Parses header / payload / footer framing and routes each payload to one of 8 per-channel AXIS-style outputs.
- Marks the first payload beat with TUSER and the last with TLAST; outputs have no TREADY.
- Maintains error and frame counters for link monitoring.

Parameters:
- M_AXIS_TDATA_WIDTH, 64, per-channel output data width.
- TX_RX_S_AXIS_WIDTH, 64, serialized input word width (must equal M_AXIS_TDATA_WIDTH).
- HEADER_ID, 8'hAA, required value of header bits [63:56].
- FOOTER_ID, 8'h55, required value of footer bits [63:56].
- MAX_FRAME_WORDS, 1600, maximum legal payload length in words.

Ports:
- RX_ACLK  in  1  single clock.
- RX_ARESETN  in  1  synchronous active-low reset.
- SERIALIZED_DATA  in  TX_RX_S_AXIS_WIDTH  RX FIFO read data; valid the cycle after RE_EN with DATA_EMPTY low.
- DATA_EMPTY  in  1  RX FIFO empty.
- PLS_WAIT  in  1  downstream stall request; suppresses new reads.
- RE_EN  out  1  RX FIFO read enable.
- Mk_AXIS_TDATA (k=0..7)  out  M_AXIS_TDATA_WIDTH  channel k payload.
- Mk_AXIS_TVALID (k=0..7)  out  1  channel k beat valid.
- Mk_AXIS_TUSER (k=0..7)  out  1  first payload beat of a frame.
- Mk_AXIS_TLAST (k=0..7)  out  1  last payload beat of a frame.
- FRAME_CNT  out  16  good frames delivered, wraps.
- HEADER_ERR_CNT  out  16  rejected header words, saturates at 16'hFFFF.
- DROP_CNT  out  16  frames dropped for bad channel id, saturates.
- FOOTER_ERR  out  1  one-cycle pulse on footer mismatch.

Behaviour:
- Reset (RX_ARESETN=0 at posedge): state IDLE; RE_EN, all TVALID/TUSER/TLAST and FOOTER_ERR = 0; all TDATA = 0; all counters = 0. A read issued in the reset cycle is discarded.
- Read side:
  - RE_EN = !DATA_EMPTY & !PLS_WAIT & RX_ARESETN (combinational).
  - word_valid is RE_EN registered once; SERIALIZED_DATA is sampled only when word_valid = 1.
- Header format:
  - [63:56] = HEADER_ID.
  - [51:48] = channel id.
  - [47:32] = payload length L in words.
  - All other bits are ignored.
- FSM, advancing only on word_valid:
  - IDLE:
    - If [63:56] = HEADER_ID and 1 ≤ L ≤ MAX_FRAME_WORDS: latch ch and L; go to PAYLOAD if ch < 8, otherwise DROP.
    - Otherwise: HEADER_ERR_CNT+1 and stay in IDLE (hunt for the next header).
  - PAYLOAD:
    - Drive word to Mch_AXIS_TDATA with TVALID = 1 in the following cycle (1-cycle registered latency).
    - TUSER = 1 on beat 1; TLAST = 1 on beat L; for L = 1 both are set on the same beat.
    - Remaining-count decrements per beat; after beat L go to FOOTER.
  - DROP: consume L words with no output; go to FOOTER; DROP_CNT+1 on entry.
  - FOOTER:
    - If [63:56] = FOOTER_ID: FRAME_CNT+1, only if the frame was not dropped.
    - Otherwise: FOOTER_ERR pulses one cycle; the word is consumed, not re-parsed as a header.
    - Next state is IDLE in both cases.
- Outputs:
  - TVALID/TUSER/TLAST are single-cycle strobes and are 0 on every cycle without an emitted beat.
  - Only one channel is active per cycle.
  - TDATA holds its last value when not valid.
- Boundaries:
  - Gaps (DATA_EMPTY or PLS_WAIT) mid-frame only stretch the frame; beat count and TUSER/TLAST placement are unchanged.
  - L = 0 or L > MAX_FRAME_WORDS is a header error.
  - Reset mid-frame: the partial frame is abandoned with no TLAST; the next word after reset is parsed as a potential header.
  - A footer mismatch after a delivered payload does not retract TLAST (it has already been emitted).
- Counters: HEADER_ERR_CNT and DROP_CNT saturate; FRAME_CNT wraps 16'hFFFF→0.

Test Plan:
- Header ch=3 L=4, 4 payload words, good footer, FIFO never empty -> M3 TVALID for 4 consecutive cycles starting 2 cycles after the header's RE_EN; TUSER on beat 1, TLAST on beat 4; FRAME_CNT = 1; other channels idle.
- Header ch=5 L=1 -> single M5 beat with TUSER = TLAST = 1.
- Frame ch=0 L=3 with DATA_EMPTY asserted 2 cycles between beats 1 and 2, and PLS_WAIT for 3 cycles before beat 3 -> still exactly 3 beats, correct TUSER/TLAST; no reads while PLS_WAIT = 1.
- Garbage word 0x1234... then header ch=9 L=2, 2 words, footer -> HEADER_ERR_CNT = 1, DROP_CNT = 1, no TVALID on any channel, FRAME_CNT = 0.
- Header ch=2 L=2, 2 words, footer byte 0x00 -> 2 beats on M2 with TLAST, FOOTER_ERR pulses once, FRAME_CNT = 0; next valid frame is decoded normally.
- Reset asserted after beat 2 of an L=5 frame, then a fresh ch=1 L=2 frame -> all outputs 0 during reset; M1 receives 2 beats; no stray beats on the old channel.
